// File: rtl/ram_pkg.sv
// Shared types and constants for the valid-masked dual-port RAM.
// Holds the clear-sequencer state encoding and the depth helper.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int unsigned depth_of(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clearing sequencer: sweeps every address once with a zero-write
// strobe and flags busy for exactly that window.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic         busy_o,
  output logic [N-1:0] clr_addr,
  output logic         clr_we
);

  localparam logic [N:0] LAST = (N+1)'(depth_of(N) - 32'd1);

  clr_state_t state;
  logic [N:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= IDLE;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Masked by reset so busy reads 0 while reset is held, yet the sweep
  // still covers exactly 2**N cycles once reset is released.
  assign clr_we   = (state == CLEAR) && !rst_i;
  assign busy_o   = clr_we;
  assign clr_addr = cnt[N-1:0];

endmodule

// File: rtl/ram_valid_dp.sv
// Simple-dual-port RAM with per-word valid bitmap, registered read,
// write-first bypass, single/bulk invalidate and a post-reset clear sweep.
module ram_valid_dp
  import ram_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned M              = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wren_i,
  input  logic [N-1:0] wr_addr_i,
  input  logic [M-1:0] dato_write_i,
  input  logic         rden_i,
  input  logic [N-1:0] rd_addr_i,
  output logic [M-1:0] dato_read_o,
  output logic         rd_valid_o,
  output logic         rd_hit_o,
  input  logic         inv_i,
  input  logic [N-1:0] inv_addr_i,
  input  logic         inv_all_i,
  output logic         busy_o
);

  localparam int unsigned DEPTH = depth_of(N);

  logic [M-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic             busy;
  logic             clr_we;
  logic [N-1:0]     clr_addr;
  logic             active;
  logic             wr_bypass;

  ram_clear_seq #(
    .N              (N),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .busy_o   (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign busy_o    = busy;
  assign active    = !rst_i && !busy;
  assign wr_bypass = wren_i && (wr_addr_i == rd_addr_i);

  // Later assignments win: write > single invalidate > bulk invalidate.
  always_comb begin
    valid_nxt = valid;
    if (inv_all_i) valid_nxt = '0;
    if (inv_i)     valid_nxt[inv_addr_i] = 1'b0;
    if (wren_i)    valid_nxt[wr_addr_i]  = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (active && wren_i) begin
      mem[wr_addr_i] <= dato_write_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= '0;
    end else if (!busy) begin
      valid <= valid_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dato_read_o <= '0;
      rd_valid_o  <= 1'b0;
      rd_hit_o    <= 1'b0;
    end else if (active && rden_i) begin
      rd_valid_o <= 1'b1;
      if (wr_bypass) begin
        dato_read_o <= dato_write_i;
        rd_hit_o    <= 1'b1;
      end else begin
        dato_read_o <= valid[rd_addr_i] ? mem[rd_addr_i] : '0;
        rd_hit_o    <= valid[rd_addr_i];
      end
    end else begin
      rd_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_valid_dp.sv
// Bench for ram_valid_dp: directed scenarios plus randomized traffic checked
// against an array-based reference model of the RAM and its valid flags.
module tb_ram_valid_dp;

  localparam int unsigned N = 4;
  localparam int unsigned M = 4;
  localparam int unsigned D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wren, rden, inv, inv_all;
  logic [N-1:0] wa, ra, ia;
  logic [M-1:0] wd;
  logic [M-1:0] dato;
  logic         rd_valid, rd_hit, busy;

  int checks   = 0;
  int failures = 0;

  logic [M-1:0] mem_m [D];
  bit           val_m [D];
  logic         exp_valid, exp_hit;
  logic [M-1:0] exp_data;

  always #5 clk = ~clk;

  ram_valid_dp #(
    .N              (N),
    .M              (M),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wren_i       (wren),
    .wr_addr_i    (wa),
    .dato_write_i (wd),
    .rden_i       (rden),
    .rd_addr_i    (ra),
    .dato_read_o  (dato),
    .rd_valid_o   (rd_valid),
    .rd_hit_o     (rd_hit),
    .inv_i        (inv),
    .inv_addr_i   (ia),
    .inv_all_i    (inv_all),
    .busy_o       (busy)
  );

  task automatic drive(input logic w, input logic [N-1:0] a_w, input logic [M-1:0] d,
                       input logic r, input logic [N-1:0] a_r,
                       input logic i, input logic [N-1:0] a_i, input logic i_all);
    wren = w; wa = a_w; wd = d; rden = r; ra = a_r; inv = i; ia = a_i; inv_all = i_all;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  // After a completed clear sweep every word is zero and nothing is valid.
  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      mem_m[i] = '0;
      val_m[i] = 1'b0;
    end
    exp_valid = 1'b0; exp_hit = 1'b0; exp_data = '0;
  endtask

  // Model one idle-state cycle: the read sees pre-edge contents unless a write
  // to the same address lands together with it; then state updates apply.
  task automatic step();
    if (rden) begin
      exp_valid = 1'b1;
      if (wren && wa == ra) begin
        exp_hit = 1'b1; exp_data = wd;
      end else begin
        exp_hit  = val_m[ra];
        exp_data = val_m[ra] ? mem_m[ra] : '0;
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (inv_all) for (int i = 0; i < D; i++) val_m[i] = 1'b0;
    if (inv) val_m[ia] = 1'b0;
    if (wren) begin
      val_m[wa] = 1'b1; mem_m[wa] = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd3, 4'd5, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_valid, rd_hit, dato, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b hit=%b data=%h busy=%b, want all 0",
               rd_valid, rd_hit, dato, busy);
    end
    rst = 1'b0;
    idle();
    model_clear();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_release: got %b want 1", busy);
    end
  endtask

  task automatic test_clear_ignored();
    int n = 0;
    drive(1'b1, 4'd0, 4'hF, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1);
    while (busy === 1'b1 && n < 40) begin
      checks++;
      if (rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL busy_rd_valid: got %b want 0 at busy cycle %0d", rd_valid, n);
      end
      n++;
      @(posedge clk); #1;
    end
    idle();
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL clear_duration: got %0d busy cycles want 16", n);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b1, (k == 0) ? 4'd0 : 4'd5, 1'b0, 4'd0, 1'b0);
      step();
      checks++;
      if ({rd_valid, rd_hit, dato} !== {1'b1, 1'b0, 4'h0}) begin
        failures++;
        $display("FAIL read_after_clear: got valid=%b hit=%b data=%h want 1 0 0",
                 rd_valid, rd_hit, dato);
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int n = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_in_reset: got %b want 0", busy);
    end
    rst = 1'b0;
    model_clear();
    #1;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL restart_duration: got %0d busy cycles want 16", n);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'd3, 4'hA, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
    step();
    checks++;
    if ({rd_valid, rd_hit, dato} !== {1'b1, 1'b1, 4'hA}) begin
      failures++;
      $display("FAIL write_read: got valid=%b hit=%b data=%h want 1 1 a", rd_valid, rd_hit, dato);
    end
    idle();
    step();
    checks++;
    if ({rd_valid, rd_hit, dato} !== {1'b0, 1'b1, 4'hA}) begin
      failures++;
      $display("FAIL read_hold: got valid=%b hit=%b data=%h want 0 1 a", rd_valid, rd_hit, dato);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd9, 4'h7, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0);
    step();
    checks++;
    if ({rd_valid, rd_hit, dato} !== {1'b1, 1'b1, 4'h7}) begin
      failures++;
      $display("FAIL bypass: got valid=%b hit=%b data=%h want 1 1 7", rd_valid, rd_hit, dato);
    end
    idle();
  endtask

  task automatic test_invalidate();
    drive(1'b1, 4'd2, 4'h6, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); step();
    drive(1'b1, 4'd4, 4'hC, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); step();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0); step();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0); step();
    checks++;
    if ({rd_valid, rd_hit, dato} !== {1'b1, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL inv_read2: got valid=%b hit=%b data=%h want 1 0 0", rd_valid, rd_hit, dato);
    end
    // Read concurrent with invalidate of the same entry sees the old state.
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 1'b1, 4'd4, 1'b0); step();
    checks++;
    if ({rd_valid, rd_hit, dato} !== {1'b1, 1'b1, 4'hC}) begin
      failures++;
      $display("FAIL inv_same_cycle: got valid=%b hit=%b data=%h want 1 1 c", rd_valid, rd_hit, dato);
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0); step();
    checks++;
    if ({rd_valid, rd_hit, dato} !== {1'b1, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL inv_read4: got valid=%b hit=%b data=%h want 1 0 0", rd_valid, rd_hit, dato);
    end
    idle();
  endtask

  task automatic test_inv_all();
    for (int a = 0; a < D; a++) begin
      drive(1'b1, 4'(a), 4'($urandom_range(15)), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step();
    end
    drive(1'b1, 4'd1, 4'h5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    step();
    for (int a = 0; a < D; a++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b1, 4'(a), 1'b0, 4'd0, 1'b0);
      step();
      checks++;
      if ({rd_valid, rd_hit, dato} !== {1'b1, (a == 1), (a == 1) ? 4'h5 : 4'h0}) begin
        failures++;
        $display("FAIL inv_all_read addr=%0d: got valid=%b hit=%b data=%h want valid=1 hit=%b data=%h",
                 a, rd_valid, rd_hit, dato, (a == 1), (a == 1) ? 4'h5 : 4'h0);
      end
    end
    idle();
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_end: got rd_valid=%b want 0", rd_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15)),
            ($urandom_range(7) == 0), 4'($urandom_range(15)), ($urandom_range(31) == 0));
      if ($urandom_range(3) == 0) ra = wa;
      step();
      checks++;
      if ({rd_valid, rd_hit, dato} !== {exp_valid, exp_hit, exp_data}) begin
        failures++;
        $display("FAIL random cycle %0d: got valid=%b hit=%b data=%h want valid=%b hit=%b data=%h",
                 c, rd_valid, rd_hit, dato, exp_valid, exp_hit, exp_data);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_clear_ignored();
    test_mid_reset();
    test_write_read();
    test_bypass();
    test_invalidate();
    test_inv_all();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_valid_dp.md
# ram_valid_dp

Parametrised simple-dual-port RAM with a per-word valid bitmap, registered read, and a post-reset clearing sequencer. It extends the single-port valid-masked RAM with separate read and write ports, write-first bypass, single-entry and bulk invalidation, and a `busy_o` window while contents are zeroed. It is the storage primitive for lookup and table blocks that must distinguish written entries from stale ones.

## Interface
- `N`, 4: address width; depth is 2**N words.
- `M`, 4: data width.
- `CLEAR_ON_RESET`, 1: when 1, zero every RAM word after reset; when 0, only the valid bitmap is cleared.

- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `wren_i` in 1: write request.
- `wr_addr_i` in N: write address.
- `dato_write_i` in M: write data.
- `rden_i` in 1: read request.
- `rd_addr_i` in N: read address.
- `dato_read_o` out M: read data, registered.
- `rd_valid_o` out 1: one-cycle pulse; `dato_read_o`/`rd_hit_o` updated this cycle.
- `rd_hit_o` out 1: the addressed entry was valid.
- `inv_i` in 1: invalidate one entry.
- `inv_addr_i` in N: invalidate address.
- `inv_all_i` in 1: invalidate all entries.
- `busy_o` out 1: clear sequence in progress; requests ignored.

## Operation
- **Reset** (while `rst_i`=1 on an edge):
  - VALID is all 0; `dato_read_o`=0; `rd_valid_o`=0; `rd_hit_o`=0; `busy_o`=0.
  - The FSM goes to CLEAR if `CLEAR_ON_RESET`=1, else to IDLE.
- **FSM states:** IDLE and CLEAR.
  - CLEAR writes 0 to RAM[cnt] and increments `cnt` from 0.
  - When `cnt` = 2**N-1 is written, the FSM moves to IDLE.
  - `busy_o`=1 exactly while in CLEAR.
- **During CLEAR:** `wren_i`, `rden_i`, `inv_i` and `inv_all_i` are ignored (dropped, not queued). `rd_valid_o` stays 0.
- **Write (IDLE):** RAM[`wr_addr_i`] <= `dato_write_i`; VALID[`wr_addr_i`] <= 1.
- **Read (IDLE, `rden_i`=1):** on the next edge:
  - `rd_valid_o`=1 and `rd_hit_o`=VALID[`rd_addr_i`].
  - `dato_read_o` = RAM[`rd_addr_i`] if valid, else all zeros.
- **No read:** `rd_valid_o`=0; `dato_read_o` and `rd_hit_o` hold their last values.
- **Read/write same address, same cycle:** write-first. The read returns `dato_write_i` with `rd_hit_o`=1.
- **Invalidate:** `inv_i` clears VALID[`inv_addr_i`]. `inv_all_i` clears every VALID bit in one cycle; RAM contents are untouched.
- **Priority per entry, same cycle:** write > `inv_i` > `inv_all_i`.
  - A write plus `inv_all_i` leaves only the written entry valid.
  - A read of a concurrently invalidated address returns the pre-edge VALID/data (invalidate is not bypassed; only writes are).
- **Widths:** `cnt` is N+1 bits so that termination is explicit; no truncation of addresses.

## Timing
- Read latency: 1 cycle from `rden_i` to `rd_valid_o`. Back-to-back reads are supported every cycle.
- Write and invalidate take effect at the edge: a read issued in the following cycle sees the new state.
- Clear duration: exactly 2**N cycles of `busy_o`=1, starting the first cycle after `rst_i` deasserts (16 cycles at N=4).
- Reset mid-CLEAR restarts the sweep at `cnt`=0 and re-clears VALID.
- Reset mid-read: `rd_valid_o` is 0 on the next cycle; the pending read is discarded.

## Structure
- Package `ram_pkg`: state encoding (IDLE, CLEAR) and the depth constant helper 2**N.
- Sub-module `ram_clear_seq`: owns the FSM, `cnt` and `busy_o`, and drives the clear address and clear-write strobe.
- The top-level block holds the RAM array, the VALID bitmap, the port muxing and the read register.

## Test plan
- **Reset/clear:** `CLEAR_ON_RESET`=1, N=4, release reset → `busy_o` high for 16 cycles. Then `rden_i` at addr 5 → `rd_hit_o`=0 and `dato_read_o`=0.
- **Write then read:** write 0xA to addr 3, read addr 3 next cycle → one cycle later `rd_valid_o`=1, `rd_hit_o`=1, `dato_read_o`=0xA.
- **Bypass:** in the same cycle, write 0x7 to addr 9 and read addr 9 → next cycle `dato_read_o`=0x7, `rd_hit_o`=1.
- **Invalidate:** write addr 2 and addr 4, then `inv_i` at addr 2, then read both:
  - addr 2 → `rd_hit_o`=0, data 0.
  - addr 4 → `rd_hit_o`=1.
- **Bulk invalidate with write:** fill all 16 entries, then `inv_all_i` together with a write of 0x5 to addr 1 → only addr 1 reads back with hit=1 (value 0x5); the other 15 read hit=0.
- **Ignored during busy:** assert `wren_i` (addr 0, 0xF) during CLEAR → after clear, a read of addr 0 gives `rd_hit_o`=0. A reset pulse mid-clear restarts the full 16-cycle `busy_o` window.
